// File: rtl/gemm_accel_top.sv
// Tiled signed GEMM engine: 4x4 PE mesh, k-inner tile loop over block-packed A/B/C SRAMs.
// Define GEMM_ASSERTIONS_EN to compile in simulation-time protocol checks.

module gemm_pe #(
    parameter int InDataWidth  = 8,
    parameter int OutDataWidth = 32,
    parameter int tileSize     = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            load,
    input  logic [tileSize*InDataWidth-1:0] a,
    input  logic [tileSize*InDataWidth-1:0] b,
    output logic [OutDataWidth-1:0]         acc
);
    logic signed [2*InDataWidth-1:0] prod;
    logic        [OutDataWidth-1:0]  sum;

    always_comb begin
        prod = '0;
        sum  = '0;
        for (int t = 0; t < tileSize; t++) begin
            prod = $signed(a[t*InDataWidth +: InDataWidth]) * $signed(b[t*InDataWidth +: InDataWidth]);
            sum  = sum + OutDataWidth'(prod);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (en)
            acc <= load ? sum : acc + sum;
    end
endmodule

module gemm_accel_top #(
    parameter int InDataWidth   = 8,
    parameter int OutDataWidth  = 32,
    parameter int AddrWidth     = 12,
    parameter int SizeAddrWidth = 8,
    parameter int meshRow       = 4,
    parameter int meshCol       = 4,
    parameter int tileSize      = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     start_i,
    input  logic [SizeAddrWidth-1:0]                 M_size_i,
    input  logic [SizeAddrWidth-1:0]                 K_size_i,
    input  logic [SizeAddrWidth-1:0]                 N_size_i,
    output logic [AddrWidth-1:0]                     sram_a_addr_o,
    output logic [AddrWidth-1:0]                     sram_b_addr_o,
    output logic [AddrWidth-1:0]                     sram_c_addr_o,
    input  logic [meshRow*tileSize*InDataWidth-1:0]  sram_a_rdata_i,
    input  logic [meshCol*tileSize*InDataWidth-1:0]  sram_b_rdata_i,
    output logic [meshRow*meshCol*OutDataWidth-1:0]  sram_c_wdata_o,
    output logic                                     sram_c_we_o,
    output logic                                     done_o
);
    localparam int LW = tileSize * InDataWidth;
    localparam logic [SizeAddrWidth-1:0] ONE_S = 1;
    localparam logic [AddrWidth-1:0]     ONE_A = 1;

    typedef enum logic [2:0] {IDLE, FETCH, LAST, WRITE, DONE} state_t;

    state_t                   state;
    logic [SizeAddrWidth-1:0] m_sz, k_sz, n_sz, m_cnt, n_cnt, k_cnt;
    logic                     beat_vld, beat_first;

    logic [meshRow-1:0][meshCol-1:0][OutDataWidth-1:0] acc;

    // Read data lags the address by one cycle, so the beat flags are the FETCH
    // state delayed by one; LAST exists only to absorb the final beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            m_sz          <= '0;
            k_sz          <= '0;
            n_sz          <= '0;
            m_cnt         <= '0;
            n_cnt         <= '0;
            k_cnt         <= '0;
            sram_a_addr_o <= '0;
            sram_b_addr_o <= '0;
            sram_c_addr_o <= '0;
            sram_c_we_o   <= 1'b0;
            done_o        <= 1'b0;
            beat_vld      <= 1'b0;
            beat_first    <= 1'b0;
        end else begin
            sram_c_we_o <= 1'b0;
            done_o      <= 1'b0;
            beat_vld    <= (state == FETCH);
            beat_first  <= (state == FETCH) && (k_cnt == '0);
            case (state)
                IDLE: if (start_i) begin
                    m_sz  <= M_size_i;
                    k_sz  <= K_size_i;
                    n_sz  <= N_size_i;
                    m_cnt <= '0;
                    n_cnt <= '0;
                    k_cnt <= '0;
                    sram_c_addr_o <= '0;
                    if (M_size_i == '0 || K_size_i == '0 || N_size_i == '0)
                        state <= DONE;
                    else begin
                        sram_a_addr_o <= '0;
                        sram_b_addr_o <= '0;
                        state         <= FETCH;
                    end
                end
                FETCH: begin
                    if (k_cnt == k_sz - ONE_S)
                        state <= LAST;
                    else begin
                        k_cnt         <= k_cnt + ONE_S;
                        sram_a_addr_o <= sram_a_addr_o + ONE_A;
                        sram_b_addr_o <= sram_b_addr_o + ONE_A;
                    end
                end
                LAST: begin
                    sram_c_we_o <= 1'b1;
                    state       <= WRITE;
                end
                WRITE: begin
                    sram_c_addr_o <= sram_c_addr_o + ONE_A;
                    k_cnt         <= '0;
                    // A rewinds to the row start for the next column; B steps on.
                    if (n_cnt != n_sz - ONE_S) begin
                        n_cnt         <= n_cnt + ONE_S;
                        sram_a_addr_o <= sram_a_addr_o + ONE_A - AddrWidth'(k_sz);
                        sram_b_addr_o <= sram_b_addr_o + ONE_A;
                        state         <= FETCH;
                    end else if (m_cnt != m_sz - ONE_S) begin
                        n_cnt         <= '0;
                        m_cnt         <= m_cnt + ONE_S;
                        sram_a_addr_o <= sram_a_addr_o + ONE_A;
                        sram_b_addr_o <= '0;
                        state         <= FETCH;
                    end else
                        state <= DONE;
                end
                DONE: begin
                    done_o <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < meshRow; r++) begin : g_row
        for (genvar c = 0; c < meshCol; c++) begin : g_col
            gemm_pe #(
                .InDataWidth (InDataWidth),
                .OutDataWidth(OutDataWidth),
                .tileSize    (tileSize)
            ) u_pe (
                .clk (clk_i),
                .rst (rst_i),
                .en  (beat_vld),
                .load(beat_first),
                .a   (sram_a_rdata_i[r*LW +: LW]),
                .b   (sram_b_rdata_i[c*LW +: LW]),
                .acc (acc[r][c])
            );
        end
    end

    assign sram_c_wdata_o = acc;

`ifdef GEMM_ASSERTIONS_EN
    always @(posedge clk_i) begin
        if (!rst_i) begin
            if (start_i && state != IDLE)
                $error("start_i asserted while busy");
            if (state == IDLE && start_i &&
                ((64'(M_size_i) * 64'(K_size_i) > (64'd1 << AddrWidth)) ||
                 (64'(N_size_i) * 64'(K_size_i) > (64'd1 << AddrWidth)) ||
                 (64'(M_size_i) * 64'(N_size_i) > (64'd1 << AddrWidth))))
                $error("block counts exceed SRAM address space");
            if ($isunknown(sram_c_we_o))
                $error("sram_c_we_o is X");
        end
    end
`else
`endif
endmodule

// File: tb/tb_gemm_accel_top.sv
// Directed bench for gemm_accel_top with behavioural A/B/C SRAMs and an element-level GEMM model.
module tb_gemm_accel_top;
    localparam int AW = 12;
    localparam int SW = 8;

    logic           clk = 1'b0;
    logic           rst, start;
    logic [SW-1:0]  m_size, k_size, n_size;
    logic [AW-1:0]  a_addr, b_addr, c_addr;
    logic [127:0]   a_rdata, b_rdata;
    logic [511:0]   c_wdata;
    logic           c_we, done;

    logic [127:0] amem [0:4095];
    logic [127:0] bmem [0:4095];
    logic [511:0] cmem [0:4095];
    int           wr_log[$];
    int           n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    gemm_accel_top dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
        .sram_a_addr_o(a_addr), .sram_b_addr_o(b_addr), .sram_c_addr_o(c_addr),
        .sram_a_rdata_i(a_rdata), .sram_b_rdata_i(b_rdata),
        .sram_c_wdata_o(c_wdata), .sram_c_we_o(c_we), .done_o(done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_rdata <= amem[a_addr];
            b_rdata <= bmem[b_addr];
        end
    end

    always @(posedge clk) begin
        if (c_we === 1'b1) begin
            cmem[c_addr] = c_wdata;
            wr_log.push_back(int'(c_addr));
        end
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] gold(int mb, int nb, int kb);
        logic [511:0]      w = '0;
        logic signed [7:0] av, bv;
        int                s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int j = 0; j < kb * 4; j++) begin
                    av = amem[mb*kb + j/4][(r*4 + j%4)*8 +: 8];
                    bv = bmem[nb*kb + j/4][(c*4 + j%4)*8 +: 8];
                    s  = s + av * bv;
                end
                w[(r*4 + c)*32 +: 32] = s;
            end
        return w;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            amem[i] = {$urandom, $urandom, $urandom, $urandom};
            bmem[i] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic run(input int M, input int K, input int N, input int pulse_at,
                       input int exp_cyc, input string name);
        int cyc;
        for (int i = 0; i < 4096; i++) cmem[i] = {16{32'hdeadbeef}};
        wr_log.delete();
        @(negedge clk);
        m_size = SW'(M); k_size = SW'(K); n_size = SW'(N);
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (cyc < 2000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == pulse_at) begin
                start = 1'b1;
                m_size = '0; k_size = '0; n_size = '0;
            end else
                start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
        chk($sformatf("%s_done_cycle", name), cyc, exp_cyc);
        @(negedge clk);
        chk($sformatf("%s_done_pulse", name), done, 1'b0);
        chk($sformatf("%s_num_writes", name), wr_log.size(), M * N);
        for (int i = 0; i < wr_log.size() && i < M * N; i++)
            chk($sformatf("%s_wr_addr%0d", name, i), wr_log[i], i);
        for (int mb = 0; mb < M; mb++)
            for (int nb = 0; nb < N; nb++)
                chk($sformatf("%s_tile_m%0d_n%0d", name, mb, nb), cmem[mb*N + nb], gold(mb, nb, K));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        m_size = '0; k_size = '0; n_size = '0;
        fill_random();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_b_addr", b_addr, 0);
        chk("rst_c_addr", c_addr, 0);
        chk("rst_we", c_we, 1'b0);
        chk("rst_wdata", c_wdata, 0);
        chk("rst_done", done, 1'b0);

        run(1, 1, 3, -1, 10, "m1k1n3");
        run(4, 16, 1, -1, 73, "m4k16n1");
        run(8, 8, 8, -1, 641, "m8k8n8");

        for (int i = 0; i < 16; i++) begin
            amem[i] = {16{8'h80}};
            bmem[i] = {16{8'h80}};
        end
        run(1, 16, 1, -1, 19, "neg128");
        chk("neg128_value", cmem[0], {16{32'h00100000}});

        run(0, 3, 2, -1, 1, "zero_m");

        fill_random();
        run(2, 2, 2, 3, 17, "mid_start");

        // Abort a run mid-FETCH once the accumulators already hold a partial sum.
        @(negedge clk);
        m_size = 8'd1; k_size = 8'd4; n_size = 8'd1;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_a_addr", a_addr, 0);
        chk("abort_b_addr", b_addr, 0);
        chk("abort_c_addr", c_addr, 0);
        chk("abort_we", c_we, 1'b0);
        chk("abort_wdata", c_wdata, 0);
        chk("abort_done", done, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        amem[0] = {16{8'h01}};
        bmem[0] = {16{8'hff}};
        run(1, 1, 1, -1, 4, "post_rst");
        chk("post_rst_value", cmem[0], {16{32'hfffffffc}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
